// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared state encoding and default sizes so RAM and arbiter instances agree
package ram_arbiter_pkg;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDRESS_WIDTH = 12;
  localparam int DEF_DEPTH = 4096;
endpackage

// File: rtl/ram_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin pick returning a one-hot grant, favouring the index not equal to last
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  assign gnt = &req ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port RAM between two requesters and runs a zero-fill sequencer
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  output logic                     busy,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic [DATA_WIDTH-1:0]    rdata0,
  output logic [DATA_WIDTH-1:0]    rdata1,
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_dataIn,
  input  logic [DATA_WIDTH-1:0]    ram_dataOut
);
  state_t state, state_n;
  logic [ADDRESS_WIDTH:0] cnt, cnt_n;
  logic last, last_n, idle, last_cnt;
  logic [1:0] pick;
  rr_pick2 u_pick (.req({req1, req0}), .last(last), .gnt(pick));
  assign idle = state == ST_IDLE;
  assign last_cnt = cnt == (ADDRESS_WIDTH+1)'(DEPTH - 1);
  assign gnt0 = idle && !reset && pick[0];
  assign gnt1 = idle && !reset && pick[1];
  assign busy = !idle && !reset;
  assign ram_wEn = busy || (gnt0 && we0) || (gnt1 && we1);
  assign ram_addr = busy ? cnt[ADDRESS_WIDTH-1:0] : gnt0 ? addr0 : gnt1 ? addr1 : '0;
  assign ram_dataIn = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
  assign rdata0 = ram_dataOut;
  assign rdata1 = ram_dataOut;
  always_comb begin
    state_n = idle ? (clear ? ST_CLEAR : ST_IDLE) : (last_cnt ? ST_IDLE : ST_CLEAR);
    cnt_n = (!idle && !last_cnt) ? cnt + 1'b1 : '0;
    last_n = gnt0 ? 1'b0 : gnt1 ? 1'b1 : last;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      last <= 1'b1;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      last <= last_n;
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized and directed checks of ram_arbiter against a behavioural model
module tb_ram_arbiter;
  logic clk = 0, reset = 1, clear = 0;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [3:0] addr0 = 0, addr1 = 0, ram_addr;
  logic [31:0] wdata0 = 0, wdata1 = 0, rdata0, rdata1, ram_dataIn, ram_dataOut;
  logic busy, gnt0, gnt1, rvalid0, rvalid1, ram_wEn;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic m_last = 1, m_clr = 0, p_v0 = 0, p_v1 = 0;
  logic [31:0] p_d0 = 0, p_d1 = 0;
  int m_idx = 0, n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  ram_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .clear(clear), .busy(busy),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .ram_wEn(ram_wEn), .ram_addr(ram_addr),
    .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
  );
  always @(posedge clk) begin
    if (ram_wEn) mem[ram_addr] <= ram_dataIn;
    else ram_dataOut <= mem[ram_addr];
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask
  task automatic cycle(input logic r0, w0, input logic [3:0] a0, input logic [31:0] d0,
                       input logic r1, w1, input logic [3:0] a1, input logic [31:0] d1,
                       input logic clr, rst);
    logic e0, e1;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    clear = clr; reset = rst;
    @(negedge clk);
    check("rvalid0", rvalid0, p_v0);
    check("rvalid1", rvalid1, p_v1);
    if (p_v0) check("rdata0", rdata0, p_d0);
    if (p_v1) check("rdata1", rdata1, p_d1);
    e0 = !rst && !m_clr && r0 && (!r1 || m_last);
    e1 = !rst && !m_clr && r1 && (!r0 || !m_last);
    check("gnt0", gnt0, e0);
    check("gnt1", gnt1, e1);
    check("busy", busy, !rst && m_clr);
    check("ram_wEn", ram_wEn, !rst && (m_clr || (e0 && w0) || (e1 && w1)));
    @(posedge clk);
    p_v0 = e0 && !w0; p_d0 = ref_mem[a0];
    p_v1 = e1 && !w1; p_d1 = ref_mem[a1];
    if (rst) begin
      m_clr = 0; m_last = 1;
    end else begin
      if (e0) m_last = 0;
      if (e1) m_last = 1;
      if (e0 && w0) ref_mem[a0] = d0;
      if (e1 && w1) ref_mem[a1] = d1;
      if (m_clr) begin
        ref_mem[m_idx] = 0;
        m_idx++;
        if (m_idx == 16) m_clr = 0;
      end else if (clr) begin
        m_clr = 1; m_idx = 0;
      end
    end
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic wr0(input logic [3:0] a, input logic [31:0] d);
    cycle(1, 1, a, d, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic rd0(input logic [3:0] a);
    cycle(1, 0, a, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    repeat (2) @(posedge clk);
    #1;
    cycle(1, 1, 2, 32'h11, 1, 0, 3, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    wr0(5, 32'hDEADBEEF);
    cycle(0, 0, 0, 0, 1, 0, 5, 0, 0, 0);
    check("wr_rd", rdata1, 32'hDEADBEEF);
    idle(1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 0, 5, 0, 1, 0, 5, 0, 0, 0);
    idle(1);
    wr0(5, 32'h1234);
    cycle(1, 0, 5, 0, 0, 0, 0, 0, 1, 0);
    check("rd_clr", rdata0, 32'h1234);
    for (int i = 0; i < 16; i++) cycle(1, 0, 5, 0, 1, 0, 6, 0, 0, 0);
    idle(1);
    rd0(5);
    check("fill", rdata0, 32'h0);
    wr0(3, 32'hAA);
    wr0(12, 32'hAA);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(7);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1);
    rd0(3);
    check("rst_lo", rdata0, 32'h0);
    rd0(12);
    check("rst_hi", rdata0, 32'hAA);
    wr0(9, 32'h55);
    rd0(9);
    check("raw", rdata0, 32'h55);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom), $urandom,
            $urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0);
    idle(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the game's single-port scratch RAM between two requesters: requester 0 is the game-control FSM and requester 1 is the display/score reader. The block also provides a hardware zero-fill sequencer that clears the whole RAM between hands. It sits directly in front of the RAM instance and drives its write enable, address and write data. Read data comes back on the RAM's registered read port, one cycle after the access is accepted.

## Interface
- DATA_WIDTH, 32, word width; must match the RAM.
- ADDRESS_WIDTH, 12, address width.
- DEPTH, 4096, number of words cleared by the zero-fill.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- clear  in  1  single-cycle pulse that starts the zero-fill.
- busy  out  1  high while the zero-fill runs.
- req0 / req1  in  1  access request; held until granted.
- we0 / we1  in  1  1 = write, 0 = read; qualified by reqN.
- addr0 / addr1  in  ADDRESS_WIDTH  access address.
- wdata0 / wdata1  in  DATA_WIDTH  write data.
- gnt0 / gnt1  out  1  request accepted on this rising edge; combinational.
- rvalid0 / rvalid1  out  1  read data valid this cycle; registered.
- rdata0 / rdata1  out  DATA_WIDTH  read data; both are pass-through of ram_dataOut.
- ram_wEn  out  1  RAM write enable.
- ram_addr  out  ADDRESS_WIDTH  RAM address (port 1 of the RAM only).
- ram_dataIn  out  DATA_WIDTH  RAM write data.
- ram_dataOut  in  DATA_WIDTH  RAM registered read data.

## Operation
- States: IDLE and CLEAR. Reset puts the block in IDLE with the clear counter at 0 and `last` at 1.
- **IDLE, arbitration:**
  - Only one requester asserts req: it is granted.
  - Both assert req: the one not equal to `last` is granted.
  - `last` updates to the granted index on every grant.
- **IDLE, RAM drive:** with a grant, ram_addr/ram_dataIn come from the granted requester and ram_wEn = weN. With no grant, ram_wEn = 0, ram_addr = 0 and ram_dataIn = 0.
- **IDLE, read response:** an accepted read sets rvalidN high for exactly the next cycle. rdataN = ram_dataOut during that cycle.
- **IDLE, write response:** writes have no response.
- **IDLE → CLEAR:** when clear is sampled high, the state moves to CLEAR on the next edge and the counter is set to 0. Any request granted in the same cycle as clear is still performed.
- **CLEAR:**
  - gnt0 = gnt1 = 0, busy = 1, ram_wEn = 1, ram_addr = counter, ram_dataIn = 0.
  - The counter increments every cycle.
  - After the cycle with counter = DEPTH-1, the state returns to IDLE.
  - clear is ignored while in CLEAR.
- **Reset mid-CLEAR:** IDLE on the next edge and the counter returns to 0. Already-written locations remain zero; the rest keep their contents.
- **Counter width:** ADDRESS_WIDTH+1 bits, so DEPTH = 2^ADDRESS_WIDTH terminates without wrap-around.

## Timing
- Reset values: busy 0, rvalid0/1 0, gnt0/1 0, ram_wEn 0. While reset is high, gnt is forced to 0.
- Grant is combinational from req in the same cycle. The access happens on the rising edge that ends that cycle (edge N).
- Read latency: data on rvalidN/rdataN in cycle N+1. The requester may issue its next request in cycle N+1.
- Read-after-write: write at edge N and read of the same address at edge N+1 returns the new data.
- Throughput is one access per cycle. Under contention, grants alternate 0,1,0,1.
- CLEAR lasts exactly DEPTH cycles. busy is high in cycles N+1 … N+DEPTH after clear is sampled at edge N. The first grant possible after a clear is in cycle N+DEPTH+1.
- A read accepted at edge N in the same cycle clear is sampled still gets rvalid in cycle N+1 (the first CLEAR cycle), carrying the pre-clear data.

## Structure
- Shared package/header holds:
  - state encodings ST_IDLE and ST_CLEAR;
  - the default DATA_WIDTH/ADDRESS_WIDTH/DEPTH constants, so the RAM and arbiter instances agree.
- One sub-module: rr_pick2, the 2-way round-robin pick. It takes req[1:0] and `last` and returns a one-hot grant.
- The clear FSM and counter stay in ram_arbiter.

## Test plan
All scenarios use DEPTH = 16 and ADDRESS_WIDTH = 4, with a behavioural RAM model that has a registered read and suppresses reads while writing.
- **Write then read:** req0 writes 0xDEADBEEF to addr 5; req1 reads addr 5 → gnt1 in the same cycle, rvalid1 next cycle, rdata1 = 0xDEADBEEF.
- **Contention:** after reset, req0 and req1 are held high for reads → gnt sequence 0,1,0,1. Each rvalid arrives exactly one cycle after its grant.
- **Zero-fill:** preload addr 5 = 0x1234; pulse clear → busy high for exactly 16 cycles with no grants; then reading addr 5 → 0.
- **Read concurrent with clear:** read of addr 5 (=0x1234) granted in the same cycle clear is pulsed → rvalid0 in the first busy cycle with 0x1234.
- **Reset mid-clear:** preload addr 3 and addr 12 = 0xAA; assert reset when the counter = 7 → busy 0 the next cycle; addr 3 reads 0, addr 12 reads 0xAA.
- **Back-to-back RAW:** req0 writes 0x55 to addr 9 then reads addr 9 in consecutive cycles → rdata0 = 0x55.
